xillyusb_read_packer: RTL and testbench

- Parametrised application-to-host buffer feeding one XillyUSB read stream (user_r_* side of xillyusb_core).
- Generalises the fixed read_8/read_32 streams:
  - packs IN_W-bit application words into DATA_W-bit stream words;
  - buffers them in a 2^DEPTH_LOG2-entry FIFO;
  - generates end-of-file from an application marker, flushing any partial word.
- Sits in bus_clk domain between user logic and the core's user_r_* ports.

---
 rtl/xillyusb_read_packer.sv | 170 +++++++++++++++++
 tb/tb_xillyusb_read_packer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/xillyusb_read_packer.sv
// Application-to-host packer for one XillyUSB read stream.
// Packs IN_W-bit application words little-endian into DATA_W-bit stream words,
// queues them in a 2^DEPTH_LOG2-entry FIFO and turns the application end-of-stream
// marker into the core's end-of-file, flushing any partially packed word first.
module xillyusb_read_packer #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned IN_W       = 8,
    parameter int unsigned DEPTH_LOG2 = 9
) (
    input  logic                  bus_clk,
    input  logic                  rst_n,
    input  logic                  app_wren,
    input  logic [IN_W-1:0]       app_data,
    input  logic                  app_eof,
    output logic                  app_full,
    input  logic                  user_r_rden,
    output logic [DATA_W-1:0]     user_r_data,
    output logic                  user_r_empty,
    output logic                  user_r_eof,
    input  logic                  user_r_open,
    output logic [DEPTH_LOG2:0]   fill_level,
    output logic                  overflow
);

    localparam int unsigned RATIO  = DATA_W / IN_W;
    localparam int unsigned DEPTH  = 2 ** DEPTH_LOG2;
    localparam int unsigned LANE_W = (RATIO > 1) ? $clog2(RATIO) : 1;

    localparam logic [DEPTH_LOG2:0]   CNT_FULL  = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE   = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);
    localparam logic [LANE_W-1:0]     LANE_ONE  = LANE_W'(1);
    localparam logic [LANE_W-1:0]     LANE_LAST = LANE_W'(RATIO - 1);

    logic [DATA_W-1:0]     mem [DEPTH];

    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic [LANE_W-1:0]     lane_q, lane_d;
    logic [DATA_W-1:0]     pack_q, pack_d;
    logic                  eof_pending_q, eof_pending_d;
    logic                  overflow_d;

    logic                  full;
    logic                  accept;
    logic                  eof_take;
    logic                  lane_last;
    logic                  push;
    logic                  pop;
    logic [DATA_W-1:0]     pack_merge;

    // Internal full uses the live count so it matches the registered app_full.
    assign full      = (count_q == CNT_FULL);
    assign accept    = user_r_open && app_wren && !eof_pending_q && !full;
    assign eof_take  = user_r_open && app_eof && !eof_pending_q;
    assign lane_last = (lane_q == LANE_LAST);

    // Next-state for packing, eof handling, pointers and count.
    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        lane_d        = lane_q;
        pack_d        = pack_q;
        eof_pending_d = eof_pending_q;
        overflow_d    = overflow;
        push          = 1'b0;
        pop           = 1'b0;
        pack_merge    = pack_q;

        if (accept) begin
            pack_merge[int'(lane_q) * IN_W +: IN_W] = app_data;
        end

        if (!user_r_open) begin
            // Closing the stream discards everything except the last read word.
            wr_ptr_d      = '0;
            rd_ptr_d      = '0;
            count_d       = '0;
            lane_d        = '0;
            pack_d        = '0;
            eof_pending_d = 1'b0;
            overflow_d    = 1'b0;
        end else begin
            if (app_wren && !eof_pending_q && full) begin
                overflow_d = 1'b1;
            end

            if (accept && lane_last) begin
                push   = 1'b1;
                lane_d = '0;
                pack_d = '0;
            end else if (accept) begin
                lane_d = lane_q + LANE_ONE;
                pack_d = pack_merge;
            end

            if (eof_take) begin
                eof_pending_d = 1'b1;
                // Flush only if lanes are occupied after this cycle's word is packed.
                if (!(accept && lane_last) && (accept || lane_q != '0)) begin
                    lane_d = '0;
                    pack_d = '0;
                    if (full) begin
                        overflow_d = 1'b1;
                    end else begin
                        push = 1'b1;
                    end
                end
            end

            pop = user_r_rden && (count_q != '0);

            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end

            if (push && !pop) begin
                count_d = count_q + CNT_ONE;
            end else if (pop && !push) begin
                count_d = count_q - CNT_ONE;
            end
        end
    end

    // FIFO storage; no reset needed since the count gates every read.
    always_ff @(posedge bus_clk) begin
        if (push) begin
            mem[wr_ptr_q] <= pack_merge;
        end
    end

    // State registers and registered flags derived from the post-edge count.
    always_ff @(posedge bus_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            lane_q        <= '0;
            pack_q        <= '0;
            eof_pending_q <= 1'b0;
            overflow      <= 1'b0;
            app_full      <= 1'b0;
            user_r_empty  <= 1'b1;
            user_r_eof    <= 1'b0;
            fill_level    <= '0;
            user_r_data   <= '0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            lane_q        <= lane_d;
            pack_q        <= pack_d;
            eof_pending_q <= eof_pending_d;
            overflow      <= overflow_d;
            app_full      <= (count_d == CNT_FULL);
            user_r_empty  <= (count_d == '0);
            user_r_eof    <= eof_pending_d && (count_d == '0);
            fill_level    <= count_d;
            if (pop) begin
                user_r_data <= mem[rd_ptr_q];
            end
        end
    end

endmodule

// File: tb/tb_xillyusb_read_packer.sv
// Scoreboard bench for xillyusb_read_packer (32-bit stream, byte input, 4-deep FIFO).
module tb_xillyusb_read_packer;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned IN_W       = 8;
    localparam int unsigned DEPTH_LOG2 = 2;

    logic                bus_clk;
    logic                rst_n;
    logic                app_wren;
    logic [IN_W-1:0]     app_data;
    logic                app_eof;
    logic                app_full;
    logic                user_r_rden;
    logic [DATA_W-1:0]   user_r_data;
    logic                user_r_empty;
    logic                user_r_eof;
    logic                user_r_open;
    logic [DEPTH_LOG2:0] fill_level;
    logic                overflow;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    xillyusb_read_packer #(
        .DATA_W     (DATA_W),
        .IN_W       (IN_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) dut (
        .bus_clk      (bus_clk),
        .rst_n        (rst_n),
        .app_wren     (app_wren),
        .app_data     (app_data),
        .app_eof      (app_eof),
        .app_full     (app_full),
        .user_r_rden  (user_r_rden),
        .user_r_data  (user_r_data),
        .user_r_empty (user_r_empty),
        .user_r_eof   (user_r_eof),
        .user_r_open  (user_r_open),
        .fill_level   (fill_level),
        .overflow     (overflow)
    );

    initial bus_clk = 1'b0;
    always #5 bus_clk = ~bus_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    // Monitor: every accepted read is compared against the scoreboard head.
    always @(posedge bus_clk) begin
        if (rst_n && user_r_open && user_r_rden && !user_r_empty) begin
            #1;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL read_unexpected: got %h want none", user_r_data);
            end else begin
                check("read_data", user_r_data, exp_q.pop_front());
            end
        end
    end

    task automatic step(input logic w, input logic [7:0] d, input logic e, input logic r);
        app_wren    = w;
        app_data    = d;
        app_eof     = e;
        user_r_rden = r;
        @(posedge bus_clk);
        #1;
        app_wren    = 1'b0;
        app_eof     = 1'b0;
        user_r_rden = 1'b0;
    endtask

    task automatic wr(input logic [7:0] d);
        step(1'b1, d, 1'b0, 1'b0);
    endtask

    task automatic rd();
        step(1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic close_stream();
        user_r_open = 1'b0;
        step(1'b0, 8'h00, 1'b0, 1'b0);
        user_r_open = 1'b1;
    endtask

    initial begin
        rst_n       = 1'b0;
        app_wren    = 1'b0;
        app_data    = '0;
        app_eof     = 1'b0;
        user_r_rden = 1'b0;
        user_r_open = 1'b1;
        repeat (2) @(posedge bus_clk);
        #1;
        check("rst_empty", 32'(user_r_empty), 32'd1);
        check("rst_full", 32'(app_full), 32'd0);
        check("rst_fill", 32'(fill_level), 32'd0);
        check("rst_eof", 32'(user_r_eof), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_data", user_r_data, 32'd0);
        @(negedge bus_clk);
        rst_n = 1'b1;
        @(posedge bus_clk);
        #1;

        // Four bytes pack into one little-endian word.
        wr(8'h11); wr(8'h22); wr(8'h33);
        check("t1_empty_partial", 32'(user_r_empty), 32'd1);
        exp_q.push_back(32'h4433_2211);
        wr(8'h44);
        check("t1_empty", 32'(user_r_empty), 32'd0);
        check("t1_fill1", 32'(fill_level), 32'd1);
        rd();
        check("t1_fill0", 32'(fill_level), 32'd0);
        check("t1_empty_after", 32'(user_r_empty), 32'd1);

        // Partial word flushed by a bare eof marker.
        wr(8'hAA); wr(8'hBB);
        exp_q.push_back(32'h0000_BBAA);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("t2_fill", 32'(fill_level), 32'd1);
        check("t2_eof_early", 32'(user_r_eof), 32'd0);
        rd();
        check("t2_eof", 32'(user_r_eof), 32'd1);
        wr(8'h55);
        check("t2_drop_fill", 32'(fill_level), 32'd0);
        check("t2_drop_ovf", 32'(overflow), 32'd0);
        check("t2_eof_hold", 32'(user_r_eof), 32'd1);
        close_stream();
        check("t2_close_eof", 32'(user_r_eof), 32'd0);

        // Eof with the last lane word: no extra flush word.
        wr(8'h01); wr(8'h02); wr(8'h03);
        exp_q.push_back(32'hDD03_0201);
        step(1'b1, 8'hDD, 1'b1, 1'b0);
        check("t3_fill", 32'(fill_level), 32'd1);
        rd();
        check("t3_fill0", 32'(fill_level), 32'd0);
        check("t3_eof", 32'(user_r_eof), 32'd1);
        close_stream();

        // Fill to full, overflow, drain, refill across pointer wrap.
        for (int i = 0; i < 16; i++) begin
            wr(8'(8'h10 + i));
        end
        exp_q.push_back(32'h1312_1110);
        exp_q.push_back(32'h1716_1514);
        exp_q.push_back(32'h1B1A_1918);
        exp_q.push_back(32'h1F1E_1D1C);
        check("t4_full", 32'(app_full), 32'd1);
        check("t4_fill4", 32'(fill_level), 32'd4);
        wr(8'hEE);
        check("t4_ovf", 32'(overflow), 32'd1);
        check("t4_fill_hold", 32'(fill_level), 32'd4);
        rd();
        check("t4_full_drop", 32'(app_full), 32'd0);
        rd(); rd(); rd();
        check("t4_empty", 32'(user_r_empty), 32'd1);
        for (int i = 0; i < 16; i++) begin
            wr(8'(8'h80 + i));
        end
        exp_q.push_back(32'h8382_8180);
        exp_q.push_back(32'h8786_8584);
        exp_q.push_back(32'h8B8A_8988);
        exp_q.push_back(32'h8F8E_8D8C);
        check("t4_refill", 32'(fill_level), 32'd4);
        rd(); rd(); rd(); rd();
        check("t4_fill_end", 32'(fill_level), 32'd0);
        close_stream();
        check("t4_ovf_clear", 32'(overflow), 32'd0);

        // Close mid-stream with three words queued and two lanes filled.
        for (int i = 0; i < 14; i++) begin
            wr(8'(8'h40 + i));
        end
        check("t5_fill3", 32'(fill_level), 32'd3);
        close_stream();
        check("t5_fill0", 32'(fill_level), 32'd0);
        check("t5_empty", 32'(user_r_empty), 32'd1);
        check("t5_eof", 32'(user_r_eof), 32'd0);
        check("t5_ovf", 32'(overflow), 32'd0);
        exp_q.push_back(32'hC4C3_C2C1);
        wr(8'hC1); wr(8'hC2); wr(8'hC3); wr(8'hC4);
        check("t5_lane0", 32'(fill_level), 32'd1);
        rd();

        // Asynchronous reset mid-transfer.
        wr(8'h61); wr(8'h62); wr(8'h63); wr(8'h64); wr(8'h65);
        check("t6_pre_fill", 32'(fill_level), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check("t6_empty", 32'(user_r_empty), 32'd1);
        check("t6_fill", 32'(fill_level), 32'd0);
        check("t6_full", 32'(app_full), 32'd0);
        check("t6_eof", 32'(user_r_eof), 32'd0);
        check("t6_ovf", 32'(overflow), 32'd0);
        check("t6_data", user_r_data, 32'd0);
        @(negedge bus_clk);
        rst_n = 1'b1;
        @(posedge bus_clk);
        #1;
        exp_q.push_back(32'h0403_0201);
        wr(8'h01); wr(8'h02); wr(8'h03); wr(8'h04);
        rd();
        step(1'b0, 8'h00, 1'b0, 1'b0);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
